// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event record for the PS/2 key event path.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Keyboard status/reply bytes that carry no key information outside a prefix
    localparam logic [7:0] PS2_DISC_NUL    = 8'h00;
    localparam logic [7:0] PS2_DISC_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_DISC_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_DISC_ACK    = 8'hFA;
    localparam logic [7:0] PS2_DISC_RESEND = 8'hFE;
    localparam logic [7:0] PS2_DISC_ERR    = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
    } key_evt_t;

    function automatic logic is_discard(input logic [7:0] b);
        logic r;
        case (b)
            PS2_DISC_NUL, PS2_DISC_BAT_OK, PS2_DISC_ECHO,
            PS2_DISC_ACK, PS2_DISC_RESEND, PS2_DISC_ERR: r = 1'b1;
            default:                                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word-fall-through byte FIFO; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module ps2_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en_s, rd_en_s;

    // Extra pointer MSB distinguishes full from empty when the indices meet.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Turns the PS/2 scancode byte stream into press/release key events with a
// ready/valid output, held-key tracking and a press counter.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit REPEAT_EN  = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic [7:0] held_code,
    output logic       seg_en,
    output logic [7:0] press_cnt,
    output logic       rx_overflow
);

    ps2_state_e state_q, state_d;
    key_evt_t   evt_q, evt_d, new_evt_s;
    logic       evt_valid_q, evt_valid_d;
    logic [7:0] held_code_q, held_code_d;
    logic       held_ext_q, held_ext_d;
    logic       seg_en_q, seg_en_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic       rx_overflow_q, rx_overflow_d;

    logic [7:0] fifo_head_s;
    logic       fifo_empty_s, fifo_full_s;
    logic       slot_free_s, pop_s, load_s;
    logic       ext_s, brk_s, match_s;

    assign slot_free_s = !evt_valid_q || evt_ready;
    assign pop_s       = !fifo_empty_s && slot_free_s;

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // Prefix flags carried by the current decoder state
    always_comb begin
        ext_s = 1'b0;
        brk_s = 1'b0;
        case (state_q)
            S_IDLE:    begin ext_s = 1'b0; brk_s = 1'b0; end
            S_BRK:     begin ext_s = 1'b0; brk_s = 1'b1; end
            S_EXT:     begin ext_s = 1'b1; brk_s = 1'b0; end
            S_EXT_BRK: begin ext_s = 1'b1; brk_s = 1'b1; end
            default:   begin ext_s = 1'b0; brk_s = 1'b0; end
        endcase
    end

    assign match_s = seg_en_q && (held_code_q == fifo_head_s) && (held_ext_q == ext_s);

    // Decoder: prefix sequencing, held-key tracking and press counting
    always_comb begin
        state_d     = state_q;
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        seg_en_d    = seg_en_q;
        press_cnt_d = press_cnt_q;
        load_s      = 1'b0;
        new_evt_s   = '{code: fifo_head_s, ext: ext_s, brk: brk_s, rep: 1'b0};
        if (!pop_s) begin
            state_d = state_q;
        end else if (fifo_head_s == PS2_PREFIX_EXT) begin
            state_d = S_EXT;
        end else if (fifo_head_s == PS2_PREFIX_BRK) begin
            case (state_q)
                S_IDLE:  state_d = S_BRK;
                S_EXT:   state_d = S_EXT_BRK;
                default: state_d = state_q;
            endcase
        end else if ((state_q == S_IDLE) && is_discard(fifo_head_s)) begin
            state_d = state_q;
        end else begin
            state_d = S_IDLE;
            if (brk_s) begin
                load_s   = 1'b1;
                seg_en_d = match_s ? 1'b0 : seg_en_q;
            end else if (match_s) begin
                // Typematic repeat of the held key: never counted
                load_s        = REPEAT_EN;
                new_evt_s.rep = 1'b1;
            end else begin
                load_s      = 1'b1;
                held_code_d = fifo_head_s;
                held_ext_d  = ext_s;
                seg_en_d    = 1'b1;
                press_cnt_d = press_cnt_q + 8'd1;
            end
        end
    end

    // Output slot: load on decode, otherwise hold until accepted
    always_comb begin
        evt_d         = evt_q;
        evt_valid_d   = evt_valid_q;
        rx_overflow_d = rx_overflow_q | (rx_valid && fifo_full_s && !pop_s);
        if (load_s) begin
            evt_d       = new_evt_s;
            evt_valid_d = 1'b1;
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            evt_q         <= '0;
            evt_valid_q   <= 1'b0;
            held_code_q   <= 8'h00;
            held_ext_q    <= 1'b0;
            seg_en_q      <= 1'b0;
            press_cnt_q   <= 8'h00;
            rx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            evt_q         <= evt_d;
            evt_valid_q   <= evt_valid_d;
            held_code_q   <= held_code_d;
            held_ext_q    <= held_ext_d;
            seg_en_q      <= seg_en_d;
            press_cnt_q   <= press_cnt_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    assign evt_valid   = evt_valid_q;
    assign evt_code    = evt_q.code;
    assign evt_ext     = evt_q.ext;
    assign evt_break   = evt_q.brk;
    assign evt_repeat  = evt_q.rep;
    assign held_code   = held_code_q;
    assign seg_en      = seg_en_q;
    assign press_cnt   = press_cnt_q;
    assign rx_overflow = rx_overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: two instances (repeats dropped / emitted) share
// stimulus; a keystroke-level model predicts each instance's event stream.
module tb_ps2_key_event_ctrl;

    logic       clk = 1'b0;
    logic       resetn, rx_valid, evt_ready;
    logic [7:0] rx_data;

    logic       evt_valid0, evt_ext0, evt_break0, evt_repeat0, seg_en0, rx_overflow0;
    logic [7:0] evt_code0, held_code0, press_cnt0;
    logic       evt_valid1, evt_ext1, evt_break1, evt_repeat1, seg_en1, rx_overflow1;
    logic [7:0] evt_code1, held_code1, press_cnt1;

    always #5 clk = ~clk;

    ps2_key_event_ctrl #(.FIFO_DEPTH(4), .REPEAT_EN(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .evt_valid(evt_valid0), .evt_ready(evt_ready), .evt_code(evt_code0),
        .evt_ext(evt_ext0), .evt_break(evt_break0), .evt_repeat(evt_repeat0),
        .held_code(held_code0), .seg_en(seg_en0), .press_cnt(press_cnt0),
        .rx_overflow(rx_overflow0));

    ps2_key_event_ctrl #(.FIFO_DEPTH(4), .REPEAT_EN(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .evt_valid(evt_valid1), .evt_ready(evt_ready), .evt_code(evt_code1),
        .evt_ext(evt_ext1), .evt_break(evt_break1), .evt_repeat(evt_repeat1),
        .held_code(held_code1), .seg_en(seg_en1), .press_cnt(press_cnt1),
        .rx_overflow(rx_overflow1));

    // event record: {code, ext, brk, rep}
    typedef logic [10:0] ev_t;
    ev_t exp0[$], exp1[$], obs0[$], obs1[$];

    // Keyboard model: pending prefixes and the key currently held down
    bit         m_ext, m_brk, m_seg, m_hext;
    logic [7:0] m_held, m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Record every accepted event (valid && ready at the coming edge)
    always @(negedge clk) begin
        if (resetn && evt_ready) begin
            if (evt_valid0) obs0.push_back({evt_code0, evt_ext0, evt_break0, evt_repeat0});
            if (evt_valid1) obs1.push_back({evt_code1, evt_ext1, evt_break1, evt_repeat1});
        end
    end

    function automatic void model_reset();
        m_ext = 1'b0; m_brk = 1'b0; m_seg = 1'b0; m_hext = 1'b0;
        m_held = 8'h00; m_cnt = 8'h00;
        exp0.delete(); exp1.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        bit  status_byte, same_key;
        status_byte = (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
                      (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
        if (b == 8'hE0) begin
            m_ext = 1'b1; m_brk = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!(status_byte && !m_ext && !m_brk)) begin
            same_key = m_seg && (m_held == b) && (m_hext == m_ext);
            if (m_brk) begin
                exp0.push_back({b, m_ext, 1'b1, 1'b0});
                exp1.push_back({b, m_ext, 1'b1, 1'b0});
                if (same_key) m_seg = 1'b0;
            end else if (same_key) begin
                exp1.push_back({b, m_ext, 1'b0, 1'b1});
            end else begin
                exp0.push_back({b, m_ext, 1'b0, 1'b0});
                exp1.push_back({b, m_ext, 1'b0, 1'b0});
                m_held = b; m_hext = m_ext; m_seg = 1'b1; m_cnt = m_cnt + 8'd1;
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit to_model);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        if (to_model) model_byte(b);
    endtask

    task automatic do_reset();
        resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; evt_ready = 1'b1;
        tick(); tick();
        resetn = 1'b1;
        model_reset();
        obs0.delete(); obs1.delete();
    endtask

    // Consume until both event streams are complete, then let stray bytes drain
    task automatic wait_idle(input bit rand_rdy);
        for (int i = 0; i < 400; i++) begin
            if (obs0.size() >= exp0.size() && obs1.size() >= exp1.size() &&
                !evt_valid0 && !evt_valid1) break;
            evt_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
        end
        evt_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({evt_valid0, evt_ext0, evt_break0, evt_repeat0, seg_en0, rx_overflow0,
             evt_code0, held_code0, press_cnt0} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset0 got v%b c%h h%h n%h s%b o%b required all zero",
                     evt_valid0, evt_code0, held_code0, press_cnt0, seg_en0, rx_overflow0);
        end
        n_tests++;
        if ({evt_valid1, evt_ext1, evt_break1, evt_repeat1, seg_en1, rx_overflow1,
             evt_code1, held_code1, press_cnt1} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset1 got v%b c%h h%h n%h s%b o%b required all zero",
                     evt_valid1, evt_code1, held_code1, press_cnt1, seg_en1, rx_overflow1);
        end
    endtask

    task automatic test_make_break();
        ev_t got;
        do_reset();
        send(8'h1C, 1'b1);
        wait_idle(1'b0);
        n_tests++;
        if (seg_en0 !== 1'b1 || seg_en1 !== 1'b1) begin
            n_fail++; $display("FAIL mb_seg_on got %b/%b required 1", seg_en0, seg_en1);
        end
        send(8'hF0, 1'b1); send(8'h1C, 1'b1);
        wait_idle(1'b0);
        n_tests++;
        if (seg_en0 !== 1'b0 || press_cnt0 !== 8'd1 || held_code0 !== 8'h1C) begin
            n_fail++;
            $display("FAIL mb_state got seg %b cnt %h held %h required 0 01 1c",
                     seg_en0, press_cnt0, held_code0);
        end
        send(8'hE0, 1'b1); send(8'h75, 1'b1);
        send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
        wait_idle(1'b0);
        n_tests++;
        if (seg_en0 !== 1'b0 || held_code0 !== 8'h75 || press_cnt0 !== m_cnt) begin
            n_fail++;
            $display("FAIL ext_state got seg %b held %h cnt %h required 0 75 %h",
                     seg_en0, held_code0, press_cnt0, m_cnt);
        end
        for (int i = 0; i < exp0.size(); i++) begin
            got = (i < obs0.size()) ? obs0[i] : 'x;
            n_tests++;
            if (got !== exp0[i]) begin
                n_fail++; $display("FAIL mb_evt0[%0d] got %h required %h", i, got, exp0[i]);
            end
        end
        n_tests++;
        if (obs0.size() != 4 || obs1.size() != exp1.size()) begin
            n_fail++;
            $display("FAIL mb_count got %0d/%0d required 4/%0d", obs0.size(), obs1.size(), exp1.size());
        end
    endtask

    task automatic test_repeat();
        do_reset();
        send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
        send(8'hF0, 1'b1); send(8'h1C, 1'b1);
        wait_idle(1'b0);
        n_tests++;
        if (obs0.size() != 2 || obs1.size() != 4) begin
            n_fail++; $display("FAIL rep_count got %0d/%0d required 2/4", obs0.size(), obs1.size());
        end
        for (int i = 0; i < exp1.size(); i++) begin
            n_tests++;
            if (i >= obs1.size() || obs1[i] !== exp1[i]) begin
                n_fail++;
                $display("FAIL rep_evt1[%0d] got %h required %h", i,
                         (i < obs1.size()) ? obs1[i] : 11'h7FF, exp1[i]);
            end
        end
        n_tests++;
        if (press_cnt0 !== 8'd1 || press_cnt1 !== 8'd1) begin
            n_fail++; $display("FAIL rep_cnt got %h/%h required 01", press_cnt0, press_cnt1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
        do_reset();
        evt_ready = 1'b0;
        // one event slot plus four FIFO entries: the sixth byte is lost
        for (int i = 0; i < 6; i++) send(codes[i], i < 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (evt_valid0 !== 1'b1 || evt_code0 !== 8'h15 || evt_valid1 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_hold got v%b code %h required 1 15", evt_valid0, evt_code0);
            end
        end
        n_tests++;
        if (rx_overflow0 !== 1'b1 || rx_overflow1 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ovf got %b/%b required 1", rx_overflow0, rx_overflow1);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (evt_valid0 !== 1'b1 || {evt_code0, evt_ext0, evt_break0, evt_repeat0} !== exp0[i]) begin
                n_fail++;
                $display("FAIL b2b_drain[%0d] got v%b %h required 1 %h", i, evt_valid0,
                         {evt_code0, evt_ext0, evt_break0, evt_repeat0}, exp0[i]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (evt_valid0 !== 1'b0 || press_cnt0 !== 8'd5) begin
            n_fail++; $display("FAIL b2b_end got v%b cnt %h required 0 05", evt_valid0, press_cnt0);
        end
        tick();
    endtask

    task automatic test_discard_wrap();
        logic [7:0] b;
        do_reset();
        send(8'hAA, 1'b1); send(8'hFA, 1'b1); send(8'h29, 1'b1);
        wait_idle(1'b0);
        n_tests++;
        if (obs0.size() != 1 || obs0[0] !== {8'h29, 3'b000}) begin
            n_fail++;
            $display("FAIL disc got %0d events first %h required 1 event 148", obs0.size(),
                     (obs0.size() > 0) ? obs0[0] : 11'h7FF);
        end
        do_reset();
        for (int i = 0; i < 256; i++) begin
            b = 8'(1 + (i % 127));
            if (i >= 127) send(8'hE0, 1'b1);
            send(b, 1'b1);
            if (i >= 127) send(8'hE0, 1'b1);
            send(8'hF0, 1'b1);
            send(b, 1'b1);
        end
        wait_idle(1'b0);
        n_tests++;
        if (press_cnt0 !== 8'h00 || press_cnt1 !== 8'h00 || seg_en0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap got cnt %h/%h seg %b required 00 0", press_cnt0, press_cnt1, seg_en0);
        end
        n_tests++;
        if (obs0.size() != 512 || obs0 != exp0) begin
            n_fail++; $display("FAIL wrap_evts got %0d events required 512 matching", obs0.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [6] = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h29};
        logic [7:0] disc [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        logic [7:0] seq [$];
        int         kind;
        ev_t        got;
        do_reset();
        for (int a = 0; a < 150; a++) begin
            seq.delete();
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                seq.push_back(disc[$urandom_range(0, 5)]);
            end else if (kind == 1) begin
                seq.push_back(8'hF0); seq.push_back(8'hE0);
                seq.push_back(pool[$urandom_range(0, 5)]);
            end else begin
                if ($urandom_range(0, 1) != 0) seq.push_back(8'hE0);
                if ($urandom_range(0, 2) == 0) seq.push_back(8'hF0);
                seq.push_back(pool[$urandom_range(0, 5)]);
            end
            foreach (seq[k]) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                send(seq[k], 1'b1);
                repeat ($urandom_range(0, 2)) begin
                    evt_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
            wait_idle(1'b1);
        end
        for (int i = 0; i < exp0.size(); i++) begin
            got = (i < obs0.size()) ? obs0[i] : 'x;
            n_tests++;
            if (got !== exp0[i]) begin
                n_fail++; $display("FAIL rnd_evt0[%0d] got %h required %h", i, got, exp0[i]);
            end
        end
        for (int i = 0; i < exp1.size(); i++) begin
            got = (i < obs1.size()) ? obs1[i] : 'x;
            n_tests++;
            if (got !== exp1[i]) begin
                n_fail++; $display("FAIL rnd_evt1[%0d] got %h required %h", i, got, exp1[i]);
            end
        end
        n_tests++;
        if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
            n_fail++;
            $display("FAIL rnd_count got %0d/%0d required %0d/%0d",
                     obs0.size(), obs1.size(), exp0.size(), exp1.size());
        end
        n_tests++;
        if (held_code0 !== m_held || seg_en0 !== m_seg || press_cnt0 !== m_cnt ||
            held_code1 !== m_held || seg_en1 !== m_seg || press_cnt1 !== m_cnt) begin
            n_fail++;
            $display("FAIL rnd_state got held %h seg %b cnt %h required %h %b %h",
                     held_code0, seg_en0, press_cnt0, m_held, m_seg, m_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h1C, 1'b1);
        wait_idle(1'b0);
        evt_ready = 1'b0;
        send(8'h2D, 1'b1); send(8'hE0, 1'b1); send(8'hF0, 1'b1);
        tick();
        resetn = 1'b0;
        tick();
        n_tests++;
        if ({evt_valid0, evt_ext0, evt_break0, evt_repeat0, seg_en0, rx_overflow0,
             evt_code0, held_code0, press_cnt0} !== 30'd0 || evt_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst got v%b c%h h%h n%h s%b required all zero",
                     evt_valid0, evt_code0, held_code0, press_cnt0, seg_en0);
        end
        resetn = 1'b1;
        evt_ready = 1'b1;
        model_reset();
        obs0.delete(); obs1.delete();
        send(8'h1C, 1'b1);
        wait_idle(1'b0);
        n_tests++;
        if (obs0.size() != 1 || obs0[0] !== {8'h1C, 3'b000} ||
            obs1.size() != 1 || obs1[0] !== {8'h1C, 3'b000}) begin
            n_fail++;
            $display("FAIL midrst_evt got %0d events first %h required 1 event 0e0",
                     obs0.size(), (obs0.size() > 0) ? obs0[0] : 11'h7FF);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_make_break();
        test_repeat();
        test_back_to_back();
        test_discard_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
